// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet MAC receive path.
package eth_pkg;

    localparam int unsigned LEN_W         = 12;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [47:0] ETH_BCAST     = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ERR_OK    = 2'd0,
        ERR_FCS   = 2'd1,
        ERR_LEN   = 2'd2,
        ERR_ABORT = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM,
        ST_EOF,
        ST_DROP
    } rx_state_t;

endpackage

// File: rtl/crc32_8.sv
// Byte-wide reflected CRC-32 next-state function, shared by the MAC RX checker and TX FCS generator.
module crc32_8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, byte_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_mac_rx.sv
// MAC receive framer: strips FCS via a 5-byte delay line, checks CRC-32 and length.
// Optional destination-address filter enabled by ETH_MAC_RX_ADDR_FILTER_EN.
module eth_mac_rx
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN  = 64,
    parameter int unsigned MAX_LEN  = 1518,
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       eth_ready,
    input  logic       valid_in,
    input  logic [7:0] data_in,
    output logic       valid_out,
    output logic [7:0] data_out,
    output logic       eof_out,
    output logic [1:0] err_out
);

    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    rx_state_t         state_q, state_d;
    logic [4:0][7:0]   sr_q, sr_d;
    logic [LEN_W-1:0]  len_q, len_d, len_inc_c;
    logic [31:0]       crc_q, crc_d, crc_seed_c, crc_next_c;
    logic              supp_q, supp_d;
    logic              vin_q;
    logic              valid_q, valid_d;
    logic              eof_q, eof_d;
    logic [7:0]        data_q, data_d;
    err_t              err_q, err_d;
    logic              len_err_c, fcs_err_c, filt_drop_c;

    // A new frame always starts from the CRC seed, whether it begins in IDLE or EOF.
    assign crc_seed_c = (state_q == ST_IDLE || state_q == ST_EOF) ? CRC32_INIT : crc_q;

    crc32_8 u_crc (
        .crc_in  (crc_seed_c),
        .byte_in (data_in),
        .crc_out (crc_next_c)
    );

    assign len_inc_c = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);
    assign len_err_c = (len_q < LEN_W'(MIN_LEN)) || (len_q > LEN_W'(MAX_LEN));
    assign fcs_err_c = (crc_q != CRC32_RESIDUE);

`ifdef ETH_MAC_RX_ADDR_FILTER_EN
    // DA is complete when byte 5 arrives: bytes 0..4 are held, byte 5 is on data_in.
    logic [47:0] da_c;
    logic        da_ok_c;
    assign da_c        = {sr_q, data_in};
    assign da_ok_c     = (da_c == MAC_ADDR) || (da_c == ETH_BCAST) || sr_q[4][0];
    assign filt_drop_c = (len_q == LEN_W'(5)) && !da_ok_c;
`else
    logic unused_mac_addr;
    assign unused_mac_addr = ^MAC_ADDR;
    assign filt_drop_c     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            len_q   <= '0;
            crc_q   <= CRC32_INIT;
            supp_q  <= 1'b0;
            vin_q   <= 1'b0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            supp_q  <= supp_d;
            vin_q   <= valid_in;
            valid_q <= valid_d;
            eof_q   <= eof_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        len_d   = len_q;
        crc_d   = crc_q;
        supp_d  = supp_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        data_d  = '0;
        err_d   = ERR_OK;

        case (state_q)
            ST_IDLE, ST_EOF: begin
                // In EOF only a rising valid_in starts a frame; a held-high strobe is an aborted tail.
                if (valid_in && eth_ready && (state_q == ST_IDLE || !vin_q)) begin
                    state_d = ST_FILL;
                    sr_d    = {sr_q[3:0], data_in};
                    len_d   = LEN_W'(1);
                    crc_d   = crc_next_c;
                    supp_d  = 1'b0;
                end else if (valid_in && state_q == ST_EOF) begin
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (!eth_ready) begin
                    state_d = valid_in ? ST_DROP : ST_IDLE;
                end else if (!valid_in) begin
                    state_d = ST_IDLE;
                end else begin
                    sr_d  = {sr_q[3:0], data_in};
                    len_d = len_inc_c;
                    crc_d = crc_next_c;
                    if (len_q == LEN_W'(4)) begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                if (!eth_ready) begin
                    if (supp_q) begin
                        state_d = valid_in ? ST_DROP : ST_IDLE;
                    end else begin
                        state_d = ST_EOF;
                        valid_d = 1'b1;
                        eof_d   = 1'b1;
                        err_d   = ERR_ABORT;
                        data_d  = sr_q[4];
                    end
                end else if (valid_in) begin
                    sr_d    = {sr_q[3:0], data_in};
                    len_d   = len_inc_c;
                    crc_d   = crc_next_c;
                    supp_d  = supp_q | filt_drop_c;
                    valid_d = !supp_d;
                    data_d  = supp_d ? 8'h00 : sr_q[4];
                end else if (supp_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_EOF;
                    valid_d = 1'b1;
                    eof_d   = 1'b1;
                    data_d  = sr_q[4];
                    if (len_err_c) begin
                        err_d = ERR_LEN;
                    end else if (fcs_err_c) begin
                        err_d = ERR_FCS;
                    end else begin
                        err_d = ERR_OK;
                    end
                end
            end
            ST_DROP: begin
                if (!valid_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign eof_out   = eof_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_eth_mac_rx.sv
// Scoreboard bench for eth_mac_rx: directed frames, expected beats queued at issue, checked by a monitor.
module tb_eth_mac_rx;

    localparam logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01;

    logic       clk = 1'b0;
    logic       reset;
    logic       eth_ready;
    logic       valid_in;
    logic [7:0] data_in;
    logic       valid_out;
    logic [7:0] data_out;
    logic       eof_out;
    logic [1:0] err_out;

    typedef struct packed {
        logic [7:0] data;
        logic       eof;
        logic [1:0] err;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] frm[$];
    bit         frm_fcs_bad;
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         first_in_cyc = 0;
    int         first_out_cyc = -1;
    bit         track_first = 1'b0;
    int         last_eof_cyc = -1;
    int         abort_cyc = 0;
    beat_t      mon_e;
    beat_t      mon_a;

    eth_mac_rx #(
        .MIN_LEN  (64),
        .MAX_LEN  (1518),
        .MAC_ADDR (MAC_ADDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .eth_ready (eth_ready),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .eof_out   (eof_out),
        .err_out   (err_out)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit-serial LSB-first CRC-32 used to generate each frame's FCS.
    function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB8_8320;
        end
        return c;
    endfunction

    task automatic build(input int len, input int flip_idx, input bit bad_fcs,
                         input bit use_da, input logic [47:0] da_in);
        logic [31:0] c;
        logic [31:0] fcs;
        logic [7:0]  b;
        logic [47:0] da;
        da = da_in;
`ifdef ETH_MAC_RX_ADDR_FILTER_EN
        if (!use_da) begin
            use_da = 1'b1;
            da     = MAC_ADDR;
        end
`endif
        frm.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < len - 4; i++) begin
            b = 8'(i);
            if (use_da && i < 6) b = da[47 - 8*i -: 8];
            if (i == flip_idx) b = b ^ 8'h01;
            frm.push_back(b);
            // FCS covers the original payload so a flipped byte breaks the check.
            c = crc_bits(c, (i == flip_idx) ? (b ^ 8'h01) : b);
        end
        fcs = ~c;
        if (bad_fcs) fcs = fcs ^ 32'h1;
        frm.push_back(fcs[7:0]);
        frm.push_back(fcs[15:8]);
        frm.push_back(fcs[23:16]);
        frm.push_back(fcs[31:24]);
        frm_fcs_bad = bad_fcs || (flip_idx >= 0);
    endtask

    function automatic bit frame_passes();
`ifdef ETH_MAC_RX_ADDR_FILTER_EN
        logic [47:0] da;
        for (int i = 0; i < 6; i++) da[47 - 8*i -: 8] = frm[i];
        return (da == MAC_ADDR) || (da == 48'hFFFF_FFFF_FFFF) || frm[0][0];
`else
        return 1'b1;
`endif
    endfunction

    // Queue beats 0..n_beats-1; the last one carries eof with the given error code.
    task automatic expect_beats(input int n_beats, input bit with_eof, input logic [1:0] err);
        beat_t e;
        if (!frame_passes()) return;
        for (int i = 0; i < n_beats; i++) begin
            e.data = frm[i];
            e.eof  = with_eof && (i == n_beats - 1);
            e.err  = e.eof ? err : 2'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic expect_frame();
        int          l;
        logic [1:0]  err;
        l = frm.size();
        if (l < 64 || l > 1518) err = 2'd2;
        else if (frm_fcs_bad)   err = 2'd1;
        else                    err = 2'd0;
        expect_beats(l - 4, 1'b1, err);
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) first_in_cyc = cyc;
            valid_in = 1'b1;
            data_in  = frm[i];
        end
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic good_frame();
        build(64, -1, 1'b0, 1'b0, 48'h0);
        expect_frame();
        drive(64);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (valid_out) begin
                if (track_first) begin
                    first_out_cyc = cyc;
                    track_first   = 1'b0;
                end
                if (eof_out) last_eof_cyc = cyc;
                mon_a = {data_out, eof_out, err_out};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %02h eof %0b err %0d, expected no output",
                             data_out, eof_out, err_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat{data,eof,err}", 32'(mon_a), 32'(mon_e));
                end
            end else if (eof_out) begin
                check("eof_without_valid", 32'(eof_out), 32'd0);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        eth_ready = 1'b1;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        idle(3);
        check("reset_outputs", {21'd0, valid_out, eof_out, data_out, err_out}, 32'd0);
        reset = 1'b0;
        idle(2);

        // Good 64-byte frame and first-output latency.
        track_first = 1'b1;
        good_frame();
        idle(4);
        check("first_out_latency", 32'(first_out_cyc - first_in_cyc), 32'd6);

        // Data byte 10 corrupted.
        build(64, 10, 1'b0, 1'b0, 48'h0);
        expect_frame();
        drive(64);
        idle(4);

        // Runt with good FCS, then a good frame rising during the EOF cycle.
        build(44, -1, 1'b0, 1'b0, 48'h0);
        expect_frame();
        drive(44);
        good_frame();
        idle(4);

        // Giant with bad FCS: length error wins.
        build(1522, -1, 1'b1, 1'b0, 48'h0);
        expect_frame();
        drive(1522);
        idle(4);

        // 3-byte burst is silent; following frame starts right after it.
        frm.delete();
        frm.push_back(8'hAA);
        frm.push_back(8'hBB);
        frm.push_back(8'hCC);
        drive(3);
        good_frame();
        idle(4);

        // eth_ready drops at byte 30: abort eof next cycle, tail ignored.
        build(64, -1, 1'b0, 1'b0, 48'h0);
        expect_beats(26, 1'b1, 2'd3);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            valid_in  = 1'b1;
            data_in   = frm[i];
            eth_ready = !(i >= 30 && i < 33);
            if (i == 30) abort_cyc = cyc;
        end
        @(negedge clk);
        valid_in  = 1'b0;
        eth_ready = 1'b1;
        idle(4);
        check("abort_eof_latency", 32'(last_eof_cyc - abort_cyc), 32'd1);
        check("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        good_frame();
        idle(4);

        // Async reset while byte 20 is presented.
        build(64, -1, 1'b0, 1'b0, 48'h0);
        expect_beats(15, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            valid_in = 1'b1;
            data_in  = frm[i];
        end
        @(negedge clk);
        data_in = frm[20];
        #2 reset = 1'b1;
        #1 check("async_reset_outputs", {21'd0, valid_out, eof_out, data_out, err_out}, 32'd0);
        valid_in = 1'b0;
        data_in  = 8'h00;
        idle(2);
        reset = 1'b0;
        idle(2);
        check("reset_queue_empty", 32'(exp_q.size()), 32'd0);
        good_frame();
        idle(4);

`ifdef ETH_MAC_RX_ADDR_FILTER_EN
        build(64, -1, 1'b0, 1'b1, 48'h02_00_00_00_00_02);
        expect_frame();
        drive(64);
        idle(4);
        build(64, -1, 1'b0, 1'b1, 48'hFFFF_FFFF_FFFF);
        expect_frame();
        drive(64);
        idle(4);
`endif

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_mac_rx.md
Name: eth_mac_rx

Overview:
MAC receive framer sitting directly downstream of the SGMII PCS RX channel. Consumes the PCS de-preambled byte strobe (DA through FCS, contiguous valid while in frame), strips the 4-byte FCS, and checks CRC-32 and frame length. Emits a byte stream with end-of-frame marking and an error code for the user/packet-buffer logic. No backpressure anywhere, because the PCS cannot stall.

Parameters:
MIN_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive
MAX_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive
MAC_ADDR, 48'h02_00_00_00_00_01, station address; used only with the optional feature

Ports:
clk  input  1  125 MHz PCS clock; the only clock
reset  input  1  asynchronous, active-high reset
eth_ready  input  1  PCS link synchronised
valid_in  input  1  byte strobe from PCS; frame = maximal run of consecutive high cycles
data_in  input  8  received byte
valid_out  output  1  payload byte valid
data_out  output  8  payload byte (FCS removed)
eof_out  output  1  qualifies the last payload byte of a frame
err_out  output  2  valid when eof_out: 0 OK, 1 FCS error, 2 length error, 3 abort

Behaviour:
- Reset (async assert, sync release) clears all state; all outputs go to 0 and state is IDLE.
- Delay line: 5-byte shift register.
  - Byte N is output, registered, on the cycle after input byte N+5 is accepted.
  - Once the frame ends, the oldest held byte is output with eof_out on the cycle after the valid_in falling edge.
  - The remaining 4 held bytes are the FCS and are discarded.
- Frame end: valid_in high→low transition.
- FSM states:
  - IDLE: wait for valid_in. On valid_in go to FILL, load the first byte, len=1, CRC init.
  - FILL: shift bytes in until 5 are held, then go to STREAM. If valid_in drops while in FILL (frame ≤4 bytes), emit nothing and return to IDLE.
  - STREAM: each valid_in cycle emits the oldest byte and shifts the new one in. On valid_in low go to EOF.
  - EOF: single cycle. valid_out=1, eof_out=1, err_out set. Return to IDLE.
  - A new frame whose valid_in rises during the EOF cycle is loaded as the first byte (the IDLE entry action applies).
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF, computed over every byte DA..FCS.
  - Frame good iff the register equals 0xDEBB20E3 after the last byte.
- Length:
  - 12-bit counter of bytes DA..FCS, saturating at 4095.
  - Length error if len < MIN_LEN or len > MAX_LEN.
  - A giant frame is still streamed and flagged only at eof.
- Error priority: abort > length > FCS.
- eth_ready low:
  - In FILL, discard the frame.
  - In STREAM, go to EOF next cycle with err_out=3, ignoring valid_in.
  - In IDLE, ignore valid_in.
  - After an abort, any remaining high valid_in cycles of that frame are ignored until valid_in goes low.
- valid_out never asserts in consecutive frames without an eof_out between them.

Optional Feature:
Macro ETH_MAC_RX_ADDR_FILTER_EN.
- Enabled:
  - On the cycle byte 5 arrives, compare DA = bytes 0..5 (byte 0 is the first transmitted octet, DA[47:40]; byte 5 is DA[7:0]) against MAC_ADDR, broadcast FF:FF:FF:FF:FF:FF, or multicast (byte 0 bit 0 = 1).
  - On mismatch, the whole frame is silent: no valid_out and no eof_out. The FSM stays in STREAM with output suppressed until valid_in drops, then returns to IDLE.
- Disabled: all frames pass; no comparator logic is synthesised.

Decomposition:
- Package eth_pkg:
  - CRC32_POLY and CRC32_RESIDUE constants.
  - err_t enum {ERR_OK, ERR_FCS, ERR_LEN, ERR_ABORT}.
  - ETH_BCAST constant.
  - rx_state_t enum.
- One sub-module, crc32_8: combinational byte-wide CRC-32 next-state function (crc_in[31:0], byte[7:0] → crc_out[31:0]). It is reusable by the planned MAC TX FCS generator.

Test Plan:
- 64-byte frame (60 payload 0x00..0x3B + valid FCS), contiguous valid_in:
  - 60 valid_out beats 0x00..0x3B.
  - eof_out on byte 0x3B with err_out=0.
  - First valid_out 6 cycles after the first valid_in.
- Same frame with data byte 10 XOR 0x01 → 60 beats, eof with err_out=1.
- 44-byte frame with correct FCS → 40 beats, eof with err_out=2.
- 1522-byte frame with wrong FCS → 1518 beats, eof with err_out=2 (length beats FCS).
- 3-byte burst, then a 64-byte good frame starting in the cycle after valid_in drops:
  - Nothing output for the burst.
  - Second frame intact, err_out=0.
- eth_ready deasserted at byte 30 of a 64-byte frame:
  - eof_out next cycle with err_out=3.
  - No further valid_out until a new frame.
- Async reset at byte 20 of a frame:
  - All outputs 0 immediately.
  - Next frame received correctly.
- (ETH_MAC_RX_ADDR_FILTER_EN, MAC_ADDR=02:00:00:00:00:01):
  - DA=02:00:00:00:00:02 → no output.
  - DA=FF:FF:FF:FF:FF:FF → passed.
